// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation scan controller.
package me_pkg;

  // Controller states, in rough order of a block's life cycle.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_FIRST    = 3'd2,
    ST_FILL_CUR = 3'd3,
    ST_FILL_SW  = 3'd4,
    ST_PROC     = 3'd5,
    ST_DONE     = 3'd6
  } me_state_e;

  // Default grid: 80 x 45 blocks (1280x720 with 16x16 blocks).
  localparam int DEF_BLK_X_MAX = 79;
  localparam int DEF_BLK_Y_MAX = 44;

  // Scan-order selection values.
  localparam int SCAN_RASTER     = 0;
  localparam int SCAN_SERPENTINE = 1;

  // Horizontal walking direction within a row.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/me_block_scanner.sv
// Block-position tracker: holds the current block column/row and the
// horizontal walking direction, and steps them on each advance strobe.
module me_block_scanner
  import me_pkg::*;
#(
  parameter int BLK_X_MAX  = DEF_BLK_X_MAX,
  parameter int BLK_Y_MAX  = DEF_BLK_Y_MAX,
  parameter int X_W        = 7,
  parameter int Y_W        = 7,
  parameter int SERPENTINE = SCAN_RASTER
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] blk_x,
  output logic [Y_W-1:0] blk_y,
  output logic           dir,
  output logic           row_start,
  output logic           row_end,
  output logic           last_blk
);

  localparam logic [X_W-1:0] X_LAST = X_W'(BLK_X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(BLK_Y_MAX);

  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           dir_nxt;

  // Row boundaries depend on the walking direction; in raster mode dir is
  // never toggled, so these reduce to the plain left/right edges.
  always_comb begin
    row_start = (dir == DIR_LEFT) ? (blk_x == X_LAST) : (blk_x == '0);
    row_end   = (dir == DIR_LEFT) ? (blk_x == '0)    : (blk_x == X_LAST);
    last_blk  = row_end && (blk_y == Y_LAST);
  end

  // Next-position computation: clear beats advance, frame wrap beats row wrap.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    x_nxt   = blk_x;
    y_nxt   = blk_y;
    dir_nxt = dir;
    if (clear) begin
      x_nxt   = '0;
      y_nxt   = '0;
      dir_nxt = DIR_RIGHT;
    end else if (advance) begin
      if (last_blk) begin
        x_nxt   = '0;
        y_nxt   = '0;
        dir_nxt = DIR_RIGHT;
      end else if (row_end) begin
        y_nxt = blk_y + 1'b1;
        if (SERPENTINE != SCAN_RASTER) begin
          dir_nxt = ~dir;
        end else begin
          x_nxt = '0;
        end
      end else if (dir == DIR_LEFT) begin
        x_nxt = blk_x - 1'b1;
      end else begin
        x_nxt = blk_x + 1'b1;
      end
    end
  end

  // Position registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_x <= '0;
      blk_y <= '0;
      dir   <= DIR_RIGHT;
    end else begin
      blk_x <= x_nxt;
      blk_y <= y_nxt;
      dir   <= dir_nxt;
    end
  end

endmodule

// File: rtl/me_scan_controller.sv
// Frame-level motion-estimation controller: walks the block grid and, per
// block, sequences current-block fill, search-window fill, PE processing and
// MV write-back. A reference-less first frame only writes MVs.
module me_scan_controller
  import me_pkg::*;
#(
  parameter int BLK_X_MAX  = DEF_BLK_X_MAX,
  parameter int BLK_Y_MAX  = DEF_BLK_Y_MAX,
  parameter int X_W        = 7,
  parameter int Y_W        = 7,
  parameter int SERPENTINE = SCAN_RASTER,
  parameter int FCNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               first_frame,
  input  logic               cur_filled,
  input  logic               sw_filled,
  input  logic               blk_done,
  output logic               busy,
  output logic               cur_fill_req,
  output logic               sw_fill_req,
  output logic               sw_fill_full,
  output logic               sw_shift_dir,
  output logic               sw_addr_en,
  output logic               mv_we,
  output logic               up_en,
  output logic [X_W+Y_W-1:0] cur_pos,
  output logic               row_end,
  output logic               frame_end,
  output logic [FCNT_W-1:0]  frame_cnt
);

  me_state_e      state, state_nxt;
  logic [X_W-1:0] blk_x;
  logic [Y_W-1:0] blk_y;
  logic           dir;
  logic           scan_row_start;
  logic           scan_row_end;
  logic           last_blk;
  logic           advance;
  logic           scan_clear;

  // A block commits once per cycle in FIRST, or on blk_done in PROC; abort
  // suppresses the commit. Position resets on abort and on frame start.
  assign advance    = !abort && ((state == ST_FIRST) ||
                                 ((state == ST_PROC) && blk_done));
  assign scan_clear = abort || ((state == ST_IDLE) && start);

  me_block_scanner #(
    .BLK_X_MAX  (BLK_X_MAX),
    .BLK_Y_MAX  (BLK_Y_MAX),
    .X_W        (X_W),
    .Y_W        (Y_W),
    .SERPENTINE (SERPENTINE)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .clear     (scan_clear),
    .advance   (advance),
    .blk_x     (blk_x),
    .blk_y     (blk_y),
    .dir       (dir),
    .row_start (scan_row_start),
    .row_end   (scan_row_end),
    .last_blk  (last_blk)
  );

  // State register.
  // NOTE: reset is asynchronous, so it sits in the sensitivity list and
  // takes effect without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_INIT;
      ST_INIT:     state_nxt = first_frame ? ST_FIRST : ST_FILL_CUR;
      ST_FIRST:    if (last_blk) state_nxt = ST_DONE;
      ST_FILL_CUR: if (cur_filled) state_nxt = ST_FILL_SW;
      ST_FILL_SW:  if (sw_filled) state_nxt = ST_PROC;
      ST_PROC:     if (blk_done) state_nxt = last_blk ? ST_DONE : ST_FILL_CUR;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
    end
  end

  // Output decode: Moore per state, with the commit strobes following advance.
  always_comb begin
    busy         = (state != ST_IDLE);
    cur_fill_req = (state == ST_FILL_CUR);
    sw_fill_req  = (state == ST_FILL_SW);
    sw_fill_full = (state == ST_FILL_SW) && scan_row_start;
    sw_shift_dir = (state == ST_FILL_SW) && dir;
    sw_addr_en   = (state == ST_PROC);
    mv_we        = advance;
    up_en        = advance;
    row_end      = advance && scan_row_end;
    frame_end    = (state == ST_DONE);
  end

  assign cur_pos = {blk_y, blk_x};

  // Completed-frame counter; an abort in DONE does not count the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if ((state == ST_DONE) && !abort) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
